// File: rtl/imm_gen_pipe_pkg.sv
// Opcode and immediate-format definitions shared by the decode-stage immediate generator.
// Build option: IMMGEN_ZICSR_EN classifies CSR-immediate SYSTEM words as format Z.
package imm_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_SH   = 3'd6,
    FMT_Z    = 3'd7
  } fmt_e;

  function automatic fmt_e classify(input logic [31:0] inst);
    fmt_e f;
    f = FMT_NONE;
    case (inst[6:0])
      OPC_LOAD, OPC_JALR: f = FMT_I;
      // funct3 001 (sll) and 101 (srl/sra) are the only OP-IMM shifts
      OPC_OPIMM: begin
        if (inst[13:12] == 2'b01) f = FMT_SH;
        else                      f = FMT_I;
      end
      OPC_STORE:          f = FMT_S;
      OPC_BRANCH:         f = FMT_B;
      OPC_LUI, OPC_AUIPC: f = FMT_U;
      OPC_JAL:            f = FMT_J;
`ifdef IMMGEN_ZICSR_EN
      OPC_SYSTEM: begin
        if (inst[14]) f = FMT_Z;
        else          f = FMT_NONE;
      end
`endif
      default:            f = FMT_NONE;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe: instruction/tag in, extended immediate/format/tag out.
interface imm_gen_pipe_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
);
  logic [31:0]      inst_i;
  logic [TAG_W-1:0] tag_i;
  logic             valid_i;
  logic             ready_o;
  logic [XLEN-1:0]  imm_o;
  logic [2:0]       fmt_o;
  logic [TAG_W-1:0] tag_o;
  logic             valid_o;
  logic             ready_i;

  modport slave (
    input  inst_i, tag_i, valid_i, ready_i,
    output ready_o, imm_o, fmt_o, tag_o, valid_o
  );

  modport master (
    output inst_i, tag_i, valid_i, ready_i,
    input  ready_o, imm_o, fmt_o, tag_o, valid_o
  );
endinterface

// File: rtl/imm_gen_pipe_skid.sv
// Generic 2-entry valid/ready skid buffer: an output register plus one overflow slot, FIFO order.
// Upstream ready comes straight from the overflow-slot flop, so it never depends on dn_ready.
module skid_buf2 #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] up_data,
  input  logic         up_valid,
  output logic         up_ready,
  output logic [W-1:0] dn_data,
  output logic         dn_valid,
  input  logic         dn_ready
);

  logic [W-1:0] out_q;
  logic [W-1:0] skid_q;
  logic         out_v;
  logic         skid_v;
  logic         push;
  logic         pop;

  // The skid slot is only ever occupied when the output register is too, so it marks "full".
  assign up_ready = ~skid_v & ~rst_i;
  assign push     = up_valid & up_ready;
  assign pop      = out_v & dn_ready;
  assign dn_data  = out_q;
  assign dn_valid = out_v;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q  <= '0;
      skid_q <= '0;
      out_v  <= 1'b0;
      skid_v <= 1'b0;
    end else if (!out_v || pop) begin
      if (skid_v) begin
        out_q  <= skid_q;
        out_v  <= 1'b1;
        skid_v <= 1'b0;
      end else begin
        out_v <= push;
        if (push) out_q <= up_data;
      end
    end else if (push) begin
      skid_q <= up_data;
      skid_v <= 1'b1;
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered, handshaked RV32I/RV64I immediate generator: combinational decode into a 2-entry skid.
// Build option: IMMGEN_ZICSR_EN (see imm_pkg) adds CSR zimm decoding; ports are identical either way.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  imm_gen_pipe_if.slave    bus
);

  localparam int unsigned W = XLEN + 3 + TAG_W;

  fmt_e            fmt;
  logic [31:0]     inst;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm;
  logic [W-1:0]    dn_data;

  assign inst = bus.inst_i;

  // Every sign-extended format fits a 32-bit signed value first, then widens to XLEN.
  always_comb begin
    fmt   = classify(inst);
    imm32 = '0;
    case (fmt)
      FMT_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
      FMT_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U:   imm32 = {inst[31:12], 12'b0};
      FMT_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    imm = XLEN'($signed(imm32));
    if (fmt == FMT_SH) begin
      imm = (XLEN == 64) ? XLEN'(inst[25:20]) : XLEN'(inst[24:20]);
    end
    if (fmt == FMT_Z) begin
      imm = XLEN'(inst[19:15]);
    end
  end

  skid_buf2 #(.W(W)) u_skid (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .up_data  ({imm, 3'(fmt), bus.tag_i}),
    .up_valid (bus.valid_i),
    .up_ready (bus.ready_o),
    .dn_data  (dn_data),
    .dn_valid (bus.valid_o),
    .dn_ready (bus.ready_i)
  );

  assign bus.imm_o = dn_data[W-1 -: XLEN];
  assign bus.fmt_o = dn_data[TAG_W +: 3];
  assign bus.tag_o = dn_data[TAG_W-1:0];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances, hand-computed directed vectors.
module tb_imm_gen_pipe;

  localparam int unsigned TAG_W = 5;

`ifdef IMMGEN_ZICSR_EN
  localparam logic [63:0] CSR_IMM = 64'h1;
  localparam logic [2:0]  CSR_FMT = 3'd7;
`else
  localparam logic [63:0] CSR_IMM = 64'h0;
  localparam logic [2:0]  CSR_FMT = 3'd0;
`endif

  typedef struct packed {
    logic [63:0]      imm;
    logic [2:0]       fmt;
    logic [TAG_W-1:0] tag;
  } item_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] imm;
    logic [2:0]  fmt;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rnd_bp = 1'b0;
  int   errors = 0;
  int   checks = 0;
  item_t q32[$];
  item_t q64[$];
  item_t e32, e64;
  vec_t  v32 [0:21];
  vec_t  v64 [0:5];

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(TAG_W)) b32 ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(TAG_W)) b64 ();

  imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (.clk_i(clk), .rst_i(rst), .bus(b32));
  imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (.clk_i(clk), .rst_i(rst), .bus(b64));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitors: pop one expectation for each transfer the DUT presents.
  always @(negedge clk) begin
    if (!rst && b32.valid_o === 1'b1 && b32.ready_i === 1'b1) begin
      if (q32.size() == 0) begin
        checks++; errors++;
        $display("FAIL out32_unexpected: got tag %0d, expected no output", b32.tag_o);
      end else begin
        e32 = q32.pop_front();
        check("imm32", 64'(b32.imm_o), e32.imm);
        check("fmt32", 64'(b32.fmt_o), 64'(e32.fmt));
        check("tag32", 64'(b32.tag_o), 64'(e32.tag));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b64.valid_o === 1'b1 && b64.ready_i === 1'b1) begin
      if (q64.size() == 0) begin
        checks++; errors++;
        $display("FAIL out64_unexpected: got tag %0d, expected no output", b64.tag_o);
      end else begin
        e64 = q64.pop_front();
        check("imm64", b64.imm_o, e64.imm);
        check("fmt64", 64'(b64.fmt_o), 64'(e64.fmt));
        check("tag64", 64'(b64.tag_o), 64'(e64.tag));
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_bp) begin
      #1;
      b32.ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the word.
  task automatic send(input bit w64, input logic [31:0] inst, input logic [TAG_W-1:0] tag,
                      input logic [63:0] imm, input logic [2:0] fmt);
    int unsigned n;
    logic rdy;
    n = 0;
    if (w64) begin
      b64.inst_i = inst; b64.tag_i = tag; b64.valid_i = 1'b1;
      q64.push_back(item_t'{imm: imm, fmt: fmt, tag: tag});
    end else begin
      b32.inst_i = inst; b32.tag_i = tag; b32.valid_i = 1'b1;
      q32.push_back(item_t'{imm: imm, fmt: fmt, tag: tag});
    end
    forever begin
      @(negedge clk);
      rdy = w64 ? b64.ready_o : b32.ready_o;
      if (rdy === 1'b1) break;
      n++;
      if (n >= 100) begin
        checks++; errors++;
        $display("FAIL accept_timeout: tag %0d not accepted, required within 100 cycles", tag);
        break;
      end
    end
    @(posedge clk); #1;
    if (w64) b64.valid_i = 1'b0;
    else     b32.valid_i = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while ((q32.size() != 0 || q64.size() != 0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (q32.size() != 0 || q64.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d items still pending, expected 0/0", q32.size(), q64.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    v32 = '{
      '{32'hFFF00093, 64'hFFFFFFFF, 3'd1},  // addi x1,x0,-1
      '{32'hFE000EE3, 64'hFFFFFFFC, 3'd3},  // beq -4
      '{32'h001000EF, 64'h00000800, 3'd5},  // jal 2048
      '{32'h123450B7, 64'h12345000, 3'd4},  // lui
      '{32'h01F09093, 64'h0000001F, 3'd6},  // slli 31
      '{32'h00000000, 64'h00000000, 3'd0},
      '{32'h00512623, 64'h0000000C, 3'd2},  // sw 12
      '{32'hFE112E23, 64'hFFFFFFFC, 3'd2},  // sw -4
      '{32'h7FF12083, 64'h000007FF, 3'd1},  // lw 2047
      '{32'h00008067, 64'h00000000, 3'd1},  // jalr
      '{32'hFFFFF097, 64'hFFFFF000, 3'd4},  // auipc
      '{32'h4050D093, 64'h00000005, 3'd6},  // srai 5
      '{32'h8000006F, 64'hFFF00000, 3'd5},  // jal min
      '{32'h7E001FE3, 64'h00000FFE, 3'd3},  // bne max
      '{32'h002081B3, 64'h00000000, 3'd0},  // add
      '{32'h3400D0F3, CSR_IMM,      CSR_FMT},
      '{32'h34009073, 64'h00000000, 3'd0},  // csrrw
      '{32'h0210D093, 64'h00000001, 3'd6},  // shamt bit 5 ignored at XLEN=32
      '{32'hFFF0A093, 64'hFFFFFFFF, 3'd1},  // slti -1
      '{32'h8000F093, 64'hFFFFF800, 3'd1},  // andi -2048
      '{32'h80004063, 64'hFFFFF000, 3'd3},  // blt min
      '{32'h00000073, 64'h00000000, 3'd0}   // ecall
    };
    v64 = '{
      '{32'h800000B7, 64'hFFFFFFFF80000000, 3'd4},
      '{32'h03F09093, 64'h000000000000003F, 3'd6},
      '{32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'd1},
      '{32'h0210D093, 64'h0000000000000021, 3'd6},
      '{32'h8000006F, 64'hFFFFFFFFFFF00000, 3'd5},
      '{32'h00512623, 64'h000000000000000C, 3'd2}
    };
    b32.inst_i = '0; b32.tag_i = '0; b32.valid_i = 1'b0; b32.ready_i = 1'b1;
    b64.inst_i = '0; b64.tag_i = '0; b64.valid_i = 1'b0; b64.ready_i = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 64'(b32.valid_o), 64'd0);
    check("rst_ready_low", 64'(b32.ready_o), 64'd0);
    check("rst_imm", 64'(b32.imm_o), 64'd0);
    check("rst_fmt", 64'(b32.fmt_o), 64'd0);
    check("rst_tag", 64'(b32.tag_o), 64'd0);
    check("rst_valid64", 64'(b64.valid_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready_high", 64'(b32.ready_o), 64'd1);
    @(posedge clk); #1;

    // Full-rate decode stream
    for (int i = 0; i < 22; i++) send(1'b0, v32[i].inst, TAG_W'(i), v32[i].imm, v32[i].fmt);
    for (int i = 0; i < 6; i++) send(1'b1, v64[i].inst, TAG_W'(i), v64[i].imm, v64[i].fmt);
    drain();

    // Same words under random downstream stalls
    rnd_bp = 1'b1;
    for (int i = 0; i < 22; i++) send(1'b0, v32[i].inst, TAG_W'(31 - i), v32[i].imm, v32[i].fmt);
    rnd_bp = 1'b0;
    @(posedge clk); #2;
    b32.ready_i = 1'b1;
    drain();

    // Back-pressure: two accepted, third held upstream, outputs stable
    b32.ready_i = 1'b0;
    send(1'b0, 32'h00100093, 5'd1, 64'h1, 3'd1);
    send(1'b0, 32'h00200093, 5'd2, 64'h2, 3'd1);
    b32.inst_i = 32'h00300093; b32.tag_i = 5'd3; b32.valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_ready", 64'(b32.ready_o), 64'd0);
      check("bp_valid", 64'(b32.valid_o), 64'd1);
      check("bp_hold_tag", 64'(b32.tag_o), 64'd1);
      check("bp_hold_imm", 64'(b32.imm_o), 64'd1);
      @(posedge clk); #1;
    end
    b32.ready_i = 1'b1;
    send(1'b0, 32'h00300093, 5'd3, 64'h3, 3'd1);
    drain();

    // Reset while both entries are held
    b32.ready_i = 1'b0;
    send(1'b0, 32'hFFF00093, 5'd9, 64'hFFFFFFFF, 3'd1);
    send(1'b0, 32'h123450B7, 5'd10, 64'h12345000, 3'd4);
    @(negedge clk);
    check("full_ready", 64'(b32.ready_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q32.delete();
    @(negedge clk);
    check("rst2_valid", 64'(b32.valid_o), 64'd0);
    check("rst2_ready", 64'(b32.ready_o), 64'd1);
    check("rst2_tag", 64'(b32.tag_o), 64'd0);
    @(posedge clk); #1;
    b32.ready_i = 1'b1;
    send(1'b0, 32'h001000EF, 5'd4, 64'h800, 3'd5);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
